sample_writeback: RTL

- Downstream stage of the notch filter datapath: drains filtered 32-bit output samples and writes them to SDRAM through an Avalon-MM master.
- Buffers samples in an internal FIFO so filter output is decoupled from SDRAM waitrequest stalls.
- Writes `sample_count` consecutive words from `base_addr` upward, then signals completion with `done` and, optionally, an interrupt.

---
 rtl/sample_writeback.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/sample_writeback.sv
// Sample writeback: buffers filtered samples in a FIFO and writes them to SDRAM over Avalon-MM.
// Optional completion interrupt is built only when SAMPLE_WRITEBACK_IRQ_EN is defined.
module sample_writeback #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned ADDR_W     = 24,
    parameter int unsigned CNT_W      = 20
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  sample_count,
    input  logic [31:0]       in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] sdaddress,
    output logic              sdwrite,
    output logic [31:0]       sdwritedata,
    input  logic              sdwaitrequest,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  written,
    output logic              irq,
    input  logic              irq_ack
);

    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned FillW = PtrW + 1;

    typedef enum logic [1:0] {StIdle, StRun, StFinish} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  written_q, written_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [FillW-1:0]  fill_q, fill_d;
    logic              sdwrite_q, sdwrite_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       mem_q [FIFO_DEPTH];

    logic fifo_full, fifo_empty, push, pop, wr_done, last_write;

    // Full flag comes from registered fill, so a same-cycle pop never frees a slot for a push.
    assign fifo_full  = (fill_q == FillW'(FIFO_DEPTH));
    assign fifo_empty = (fill_q == '0);
    assign in_ready   = (state_q == StRun) && !fifo_full && (acc_q < count_q);
    assign push       = in_valid && in_ready;
    assign wr_done    = sdwrite_q && !sdwaitrequest;
    assign pop        = (state_q == StRun) && !fifo_empty && (!sdwrite_q || !sdwaitrequest);
    assign last_write = wr_done && ((written_q + CNT_W'(1)) == count_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = (sample_count != '0) ? StRun : StFinish;
                end
            end
            StRun: begin
                if (last_write) begin
                    state_d = StFinish;
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        busy = (state_q == StRun);
        done = (state_q == StFinish);
    end

    always_comb begin
        addr_d    = addr_q;
        count_d   = count_q;
        acc_d     = acc_q;
        written_d = written_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        sdwrite_d = sdwrite_q;
        wdata_d   = wdata_q;
        fill_d    = fill_q + FillW'(push) - FillW'(pop);

        if (state_q == StIdle && start) begin
            addr_d    = base_addr & ~ADDR_W'(3);
            count_d   = sample_count;
            acc_d     = '0;
            written_d = '0;
        end
        if (push) begin
            acc_d    = acc_q + CNT_W'(1);
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (wr_done) begin
            addr_d    = addr_q + ADDR_W'(4);
            written_d = written_q + CNT_W'(1);
        end
        // Popping on the completing edge keeps back-to-back writes at one per cycle.
        if (pop) begin
            sdwrite_d = 1'b1;
            wdata_d   = mem_q[rd_ptr_q];
            rd_ptr_d  = rd_ptr_q + PtrW'(1);
        end else if (wr_done) begin
            sdwrite_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q    <= '0;
            count_q   <= '0;
            acc_q     <= '0;
            written_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            fill_q    <= '0;
            sdwrite_q <= 1'b0;
            wdata_q   <= '0;
        end else begin
            addr_q    <= addr_d;
            count_q   <= count_d;
            acc_q     <= acc_d;
            written_q <= written_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            fill_q    <= fill_d;
            sdwrite_q <= sdwrite_d;
            wdata_q   <= wdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    assign sdaddress   = addr_q;
    assign sdwrite     = sdwrite_q;
    assign sdwritedata = wdata_q;
    assign written     = written_q;

`ifdef SAMPLE_WRITEBACK_IRQ_EN
    logic irq_q, irq_d;

    // Set has priority over a coincident acknowledge.
    always_comb begin
        irq_d = irq_q;
        if (state_q == StFinish) begin
            irq_d = 1'b1;
        end else if (irq_ack) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`else
    logic unused_irq_ack;
    assign unused_irq_ack = irq_ack;
    assign irq            = 1'b0;
`endif

endmodule
